irrigation_timer_ctrl: RTL and testbench

//  Controller for the 4-bit presettable up/down counter of the irrigation timer; it sits on the counter's control side.

---
 rtl/irrigation_pkg.sv | 24 ++
 rtl/irrigation_timer_ctrl_if.sv | 32 +++
 rtl/irrigation_timer_ctrl_tick_prescaler.sv | 39 +++
 rtl/irrigation_timer_ctrl.sv | 140 ++++++++++++++
 tb/tb_irrigation_timer_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation timer controller: FSM state
// encoding, counter width/terminal value and watchdog limit.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WATER     = 3'd2,
    SOAK_LOAD = 3'd3,
    SOAK      = 3'd4,
    DONE      = 3'd5,
    FAULT     = 3'd6
  } state_e;

  localparam int             CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = 4'hF;
  localparam int             WDOG_LIMIT = 16;
  localparam int             WDOG_W     = 5;

  function automatic logic is_count_state(state_e s);
    return (s == WATER) || (s == SOAK);
  endfunction

endpackage

// File: rtl/irrigation_timer_ctrl_if.sv
// Bundle of sequencer-side (start/abort/duration, status) and counter-side
// (load/d/up_down/cten_n, q/max_min) signals of the irrigation timer controller.
interface irrigation_timer_ctrl_if;
  import irrigation_pkg::*;

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] duration;
  logic             valve_on;
  logic             busy;
  logic             done;
  logic             fault;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_up_down;
  logic             cnt_cten_n;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_max_min;

  // Controller view
  modport slave (
    input  start, abort, duration, cnt_q, cnt_max_min,
    output valve_on, busy, done, fault, cnt_load, cnt_d, cnt_up_down, cnt_cten_n
  );

  // Environment view: sequencer plus counter
  modport master (
    output start, abort, duration, cnt_q, cnt_max_min,
    input  valve_on, busy, done, fault, cnt_load, cnt_d, cnt_up_down, cnt_cten_n
  );

endinterface

// File: rtl/irrigation_timer_ctrl_tick_prescaler.sv
// Divides clk by PRESCALE while enabled; restarts from zero on clear so the
// first tick of a phase lands PRESCALE-1 cycles after entry.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int                PRE_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clear_i || !en_i) begin
      pre_d = '0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick_o = en_i && (pre_q == PRE_LAST);

endmodule

// File: rtl/irrigation_timer_ctrl.sv
// Irrigation timer controller: loads the external 4-bit counter, gates the valve
// for one watering cycle per start, with a per-phase watchdog.
// Optional soak phase after watering: define IRRIG_SOAK_PHASE_EN.
module irrigation_timer_ctrl
  import irrigation_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input logic                    clk,
  input logic                    rst,
  irrigation_timer_ctrl_if.slave ctrl_if
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dur_q, dur_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              counting;
  logic              phase_entry;
  logic              tick;
  logic              tick_eff;
  logic              wdog_expire;

  assign counting    = is_count_state(state_q);
  assign phase_entry = (state_d != state_q);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear_i (phase_entry),
    .en_i    (counting),
    .tick_o  (tick)
  );

  // Ticks are swallowed at terminal count so the counter never wraps.
  assign tick_eff    = tick & ~ctrl_if.cnt_max_min;
  assign wdog_expire = tick_eff && (wdog_q == WDOG_W'(WDOG_LIMIT - 1));

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_if.start && !ctrl_if.abort) begin
          dur_d   = ctrl_if.duration;
          state_d = LOAD;
        end
      end
      LOAD:  state_d = (dur_q != '0) ? WATER : DONE;
      WATER: begin
        if (ctrl_if.cnt_max_min) begin
`ifdef IRRIG_SOAK_PHASE_EN
          state_d = SOAK_LOAD;
`else
          state_d = DONE;
`endif
        end else if (wdog_expire) begin
          state_d = FAULT;
        end
      end
`ifdef IRRIG_SOAK_PHASE_EN
      SOAK_LOAD: state_d = SOAK;
      SOAK: begin
        if (ctrl_if.cnt_max_min) begin
          state_d = DONE;
        end else if (wdog_expire) begin
          state_d = FAULT;
        end
      end
`endif
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (ctrl_if.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    wdog_d = wdog_q;
    if (phase_entry || !counting) begin
      wdog_d = '0;
    end else if (tick_eff) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    ctrl_if.valve_on    = 1'b0;
    ctrl_if.busy        = 1'b0;
    ctrl_if.done        = 1'b0;
    ctrl_if.fault       = 1'b0;
    ctrl_if.cnt_load    = 1'b0;
    ctrl_if.cnt_d       = '0;
    ctrl_if.cnt_up_down = 1'b1;
    ctrl_if.cnt_cten_n  = ~tick_eff;
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        ctrl_if.busy     = 1'b1;
        ctrl_if.cnt_load = 1'b1;
        ctrl_if.cnt_d    = dur_q;
      end
      WATER: begin
        ctrl_if.busy     = 1'b1;
        ctrl_if.valve_on = 1'b1;
      end
`ifdef IRRIG_SOAK_PHASE_EN
      SOAK_LOAD: begin
        ctrl_if.busy        = 1'b1;
        ctrl_if.cnt_load    = 1'b1;
        ctrl_if.cnt_up_down = 1'b0;
      end
      SOAK: begin
        ctrl_if.busy        = 1'b1;
        ctrl_if.cnt_up_down = 1'b0;
      end
`endif
      DONE: begin
        ctrl_if.busy = 1'b1;
        ctrl_if.done = 1'b1;
      end
      FAULT:   ctrl_if.fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// Scoreboard bench for irrigation_timer_ctrl with a behavioural 4-bit up/down
// counter; stimulus queues expected events, a negedge monitor pops and compares.
module tb_irrigation_timer_ctrl;
  import irrigation_pkg::*;

  localparam int PRESCALE = 4;
  localparam int EV_LOAD  = 0;
  localparam int EV_VALVE = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_IDLE  = 3;
  localparam int EV_FAULT = 4;
  localparam int EV_SNAP  = 5;
  // {valve,busy,done,fault,load,d[3:0],up_down,cten_n}
  localparam logic [31:0] SNAP_IDLE  = 32'd3;
  localparam logic [31:0] SNAP_FAULT = 32'd131;
  // abort age 1, valve 0, cten_n 1
  localparam logic [31:0] IDLE_AFTER_ABORT = 32'd5;

  typedef struct {
    int          kind;
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irrigation_timer_ctrl_if bus ();

  irrigation_timer_ctrl #(.PRESCALE(PRESCALE)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  logic [3:0] q_model;
  logic       force_mm0 = 1'b0;
  logic       snap_req  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) q_model <= 4'd0;
    else if (bus.cnt_load) q_model <= bus.cnt_d;
    else if (!bus.cnt_cten_n) q_model <= bus.cnt_up_down ? q_model - 4'd1 : q_model + 4'd1;
  end
  assign bus.cnt_q       = q_model;
  assign bus.cnt_max_min = force_mm0 ? 1'b0 :
                           (bus.cnt_up_down ? (q_model == 4'd0) : (q_model == 4'hF));

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic string kname(int k);
    case (k)
      EV_LOAD:  return "load";
      EV_VALVE: return "valve_len";
      EV_DONE:  return "done";
      EV_IDLE:  return "abort_idle";
      EV_FAULT: return "fault";
      EV_SNAP:  return "snapshot";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] done_val(int job, int pulses);
    return 32'((job << 16) | pulses);
  endfunction

  task automatic expect_ev(int kind, logic [31:0] value);
    exp_q.push_back('{kind, value});
  endtask

  task automatic emit(int kind, logic [31:0] value);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s actual=0x%0h required=no event", kname(kind), value);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.value == value) begin
        n_pass++;
        $display("ok   %s value=0x%0h @%0t", kname(kind), value, $time);
      end else begin
        $display("FAIL %s actual=%s/0x%0h required=%s/0x%0h @%0t",
                 kname(e.kind), kname(kind), value, kname(e.kind), e.value, $time);
      end
    end
  endtask

  // Monitor
  int job_cycles = 0, pulses = 0, valve_len = 0, abort_age = 0;
  bit abort_seen = 0, prev_busy = 0, prev_valve = 0, prev_fault = 0, prev_done = 0, rst_prev = 1;

  always @(negedge clk) begin
    if (rst_prev) begin
      job_cycles = 0; pulses = 0; valve_len = 0; abort_seen = 0; abort_age = 0;
    end else begin
      if (bus.cnt_load && bus.cnt_up_down) begin
        job_cycles = 0;
        pulses     = 0;
      end else begin
        job_cycles++;
      end
      if (bus.cnt_load) emit(EV_LOAD, {27'd0, bus.cnt_up_down, bus.cnt_d});
      if (!bus.cnt_cten_n) pulses++;
      if (bus.valve_on) valve_len++;
      else if (prev_valve) begin
        emit(EV_VALVE, 32'(valve_len));
        valve_len = 0;
      end
      if (bus.done) emit(EV_DONE, done_val(job_cycles, pulses));
      if (abort_seen) abort_age++;
      if ((prev_busy || prev_fault) && !bus.busy && !bus.fault && !prev_done) begin
        emit(EV_IDLE, 32'(abort_age * 4 + int'(bus.valve_on) * 2 + int'(bus.cnt_cten_n)));
        abort_seen = 0;
      end
      if (bus.fault && !prev_fault) emit(EV_FAULT, 32'(pulses));
      if (bus.abort && !abort_seen) begin
        abort_seen = 1;
        abort_age  = 0;
      end
    end
    if (snap_req) emit(EV_SNAP, {21'd0, bus.valve_on, bus.busy, bus.done, bus.fault,
                                 bus.cnt_load, bus.cnt_d, bus.cnt_up_down, bus.cnt_cten_n});
    prev_busy  = bus.busy;
    prev_valve = bus.valve_on;
    prev_fault = bus.fault;
    prev_done  = bus.done;
    rst_prev   = rst;
  end

  // Stimulus
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap(logic [31:0] v);
    expect_ev(EV_SNAP, v);
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

  task automatic pulse_start(logic [3:0] d);
    bus.duration = d;
    bus.start    = 1'b1;
    cyc();
    bus.start    = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    for (int k = 0; k < 400 && bus.busy === 1'b1; k++) cyc();
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL %s_timeout busy=%b required=0", tag, bus.busy);
    else n_pass++;
  endtask

  task automatic run_job(logic [3:0] d, int vlen, int job, int npulse);
    expect_ev(EV_LOAD, 32'(16 + int'(d)));
`ifdef IRRIG_SOAK_PHASE_EN
    if (vlen > 0) expect_ev(EV_LOAD, 32'd0);
`endif
    if (vlen > 0) expect_ev(EV_VALVE, 32'(vlen));
    expect_ev(EV_DONE, done_val(job, npulse));
    pulse_start(d);
    wait_idle("job");
    snap(SNAP_IDLE);
  endtask

  initial begin
    exp_t e;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.duration = 4'd0;
    rst          = 1'b1;
    cyc(3);
    snap(SNAP_IDLE);
    rst = 1'b0;
    cyc(2);

`ifdef IRRIG_SOAK_PHASE_EN
    run_job(4'd3, 13, 76, 18);
    run_job(4'd0, 0, 1, 0);
    run_job(4'd2, 9, 72, 17);
    run_job(4'd15, 61, 124, 30);
`else
    run_job(4'd3, 13, 14, 3);
    run_job(4'd0, 0, 1, 0);
    run_job(4'd2, 9, 10, 2);
    run_job(4'd15, 61, 62, 15);
`endif

    // Abort five cycles into WATER
    expect_ev(EV_LOAD, 32'd25);
    expect_ev(EV_VALVE, 32'd6);
    expect_ev(EV_IDLE, IDLE_AFTER_ABORT);
    pulse_start(4'd9);
    cyc(6);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    snap(SNAP_IDLE);
    cyc(2);

    // Stuck terminal flag trips the watchdog
    force_mm0 = 1'b1;
    expect_ev(EV_LOAD, 32'd21);
    expect_ev(EV_VALVE, 32'd64);
    expect_ev(EV_FAULT, 32'd16);
    pulse_start(4'd5);
    for (int k = 0; k < 200 && bus.fault !== 1'b1; k++) cyc();
    n_checks++;
    if (bus.fault !== 1'b1) $display("FAIL fault_timeout fault=%b required=1", bus.fault);
    else n_pass++;
    pulse_start(4'd7);
    cyc(2);
    snap(SNAP_FAULT);
    expect_ev(EV_IDLE, IDLE_AFTER_ABORT);
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    force_mm0 = 1'b0;
    snap(SNAP_IDLE);
    cyc(2);

    // Start during WATER is ignored
    expect_ev(EV_LOAD, 32'd20);
`ifdef IRRIG_SOAK_PHASE_EN
    expect_ev(EV_LOAD, 32'd0);
    expect_ev(EV_VALVE, 32'd17);
    expect_ev(EV_DONE, done_val(80, 19));
`else
    expect_ev(EV_VALVE, 32'd17);
    expect_ev(EV_DONE, done_val(18, 4));
`endif
    pulse_start(4'd4);
    cyc(3);
    pulse_start(4'd7);
    wait_idle("start_ignored");
    snap(SNAP_IDLE);

    // Reset mid-WATER
    expect_ev(EV_LOAD, 32'd22);
    pulse_start(4'd6);
    cyc(5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    snap(SNAP_IDLE);
    cyc(5);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_%s actual=no event required=0x%0h", kname(e.kind), e.value);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
